// File: rtl/count_pkg.sv
// Shared definitions for the count-step control block: default sizing and FSM state encoding.
package count_pkg;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_ADD_LAT = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StCapt = 2'd2
    } state_e;

endpackage

// File: rtl/count_step_ctrl.sv
// Up/down counter built around an external registered adder: issues one add per step,
// waits out the adder latency, then captures sum and wrap.
module count_step_ctrl
    import count_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned ADD_LAT = DEF_ADD_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_co,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam int unsigned WCW = $clog2(ADD_LAT + 1);

    state_e           state_q;
    logic [WCW-1:0]   wait_cnt_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] add_x_q;
    logic [WIDTH-1:0] add_y_q;
    logic             add_cin_q;
    logic             up_dn_q;
    logic             busy_q;
    logic             done_q;
    logic             wrap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            count_q    <= '0;
            add_x_q    <= '0;
            add_y_q    <= '0;
            add_cin_q  <= 1'b0;
            up_dn_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        count_q <= load_val;
                        wrap_q  <= 1'b0;
                    end else if (en) begin
                        // Subtract as count + ~step + 1 so the adder only ever adds.
                        add_x_q    <= count_q;
                        add_y_q    <= up_dn ? step : ~step;
                        add_cin_q  <= ~up_dn;
                        up_dn_q    <= up_dn;
                        busy_q     <= 1'b1;
                        wait_cnt_q <= WCW'(ADD_LAT - 1);
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= StCapt;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                StCapt: begin
                    count_q <= add_s;
                    // On subtract a missing carry-out means a borrow.
                    wrap_q  <= up_dn_q ? add_co : ~add_co;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign add_x   = add_x_q;
    assign add_y   = add_y_q;
    assign add_cin = add_cin_q;
    assign count   = count_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_count_step_ctrl.sv
// Self-checking bench: count_step_ctrl plus a two-stage registered adder, directed and random steps.
module tb_count_step_ctrl;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned ADD_LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             up_dn;
    logic [WIDTH-1:0] step;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_co;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             wrap;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state, derived from integer arithmetic on the counter value.
    int count_m = 0;
    int wrap_m  = 0;
    int ox_m    = 0;
    int oy_m    = 0;
    int oc_m    = 0;

    always #5 clk = ~clk;

    count_step_ctrl #(
        .WIDTH   (WIDTH),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .step     (step),
        .load     (load),
        .load_val (load_val),
        .add_x    (add_x),
        .add_y    (add_y),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_co   (add_co),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    // Registered adder stage with two edges of latency.
    logic [WIDTH:0] sum_s1;
    logic [WIDTH:0] sum_s2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_s1 <= '0;
            sum_s2 <= '0;
        end else begin
            sum_s1 <= {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
            sum_s2 <= sum_s1;
        end
    end
    assign add_s  = sum_s2[WIDTH-1:0];
    assign add_co = sum_s2[WIDTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load     = 1'b1;
        load_val = v;
        @(posedge clk);
        #1;
        load    = 1'b0;
        count_m = int'(v);
        wrap_m  = 0;
        check("load_count", count, count_m);
        check("load_wrap", wrap, wrap_m);
        check("load_done", done, 0);
        check("load_busy", busy, 0);
    endtask

    // One step; with poke set, en and load are pulsed while the step is in flight.
    task automatic do_step(input logic u, input logic [WIDTH-1:0] st, input bit poke);
        int r;
        en    = 1'b1;
        up_dn = u;
        step  = st;
        @(posedge clk);
        #1;
        en   = 1'b0;
        ox_m = count_m;
        oy_m = u ? int'(st) : (15 - int'(st));
        oc_m = u ? 0 : 1;
        check("issue_busy", busy, 1);
        check("issue_x", add_x, ox_m);
        check("issue_y", add_y, oy_m);
        check("issue_cin", add_cin, oc_m);
        if (u) begin
            r      = count_m + int'(st);
            wrap_m = (r > 15) ? 1 : 0;
        end else begin
            r      = count_m - int'(st);
            wrap_m = (r < 0) ? 1 : 0;
        end
        count_m = r & 15;
        for (int i = 0; i < ADD_LAT; i++) begin
            @(posedge clk);
            #1;
            check("wait_done", done, 0);
            check("wait_busy", busy, 1);
            if (poke && i == 0) begin
                en       = 1'b1;
                load     = 1'b1;
                load_val = 4'(~count_m);
                up_dn    = ~u;
                step     = 4'($urandom_range(1, 15));
            end else begin
                en   = 1'b0;
                load = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("capt_done", done, 1);
        check("capt_count", count, count_m);
        check("capt_wrap", wrap, wrap_m);
        check("capt_busy", busy, 0);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("held_count", count, count_m);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        up_dn    = 1'b0;
        step     = '0;
        load     = 1'b0;
        load_val = '0;
        #1;
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wrap", wrap, 0);
        check("rst_x", add_x, 0);
        check("rst_y", add_y, 0);
        check("rst_cin", add_cin, 0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset while a step is in flight.
        do_load(4'h9);
        en    = 1'b1;
        up_dn = 1'b0;
        step  = 4'h5;
        @(posedge clk);
        #1;
        en = 1'b0;
        check("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_x", add_x, 0);
        check("mid_rst_y", add_y, 0);
        check("mid_rst_cin", add_cin, 0);
        check("mid_rst_wrap", wrap, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        count_m = 0;
        wrap_m  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_count", count, 0);
        check("post_rst_done", done, 0);
        do_step(1'b1, 4'h1, 1'b0);
        check("post_rst_step", count, 1);

        // Counting up by one, reset state onward.
        do_load(4'h0);
        for (int i = 1; i <= 3; i++) begin
            do_step(1'b1, 4'h1, 1'b0);
            check("up_seq", count, i);
            check("up_seq_wrap", wrap, 0);
        end

        do_load(4'hF);
        do_step(1'b1, 4'h1, 1'b0);
        check("up_wrap_count", count, 0);
        check("up_wrap_flag", wrap, 1);
        do_step(1'b1, 4'h2, 1'b0);
        check("up2_count", count, 2);
        check("up2_wrap", wrap, 0);

        do_load(4'h0);
        do_step(1'b0, 4'h1, 1'b0);
        check("dn_wrap_count", count, 15);
        check("dn_wrap_flag", wrap, 1);
        do_load(4'h9);
        do_step(1'b0, 4'h3, 1'b0);
        check("dn3_count", count, 6);
        check("dn3_wrap", wrap, 0);

        do_step(1'b1, 4'h0, 1'b0);
        check("up0_wrap", wrap, 0);
        do_step(1'b0, 4'h0, 1'b0);
        check("dn0_count", count, 6);
        check("dn0_wrap", wrap, 0);

        // load beats en; the en is dropped and operands stay put.
        load     = 1'b1;
        en       = 1'b1;
        up_dn    = 1'b1;
        step     = 4'h4;
        load_val = 4'h7;
        @(posedge clk);
        #1;
        load    = 1'b0;
        en      = 1'b0;
        count_m = 7;
        wrap_m  = 0;
        check("le_count", count, 7);
        check("le_busy", busy, 0);
        check("le_x", add_x, ox_m);
        check("le_y", add_y, oy_m);
        check("le_cin", add_cin, oc_m);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("le_no_done", done, 0);
            check("le_hold", count, 7);
        end

        // en/load during busy are ignored.
        do_step(1'b1, 4'h3, 1'b1);
        check("busy_ign_count", count, 10);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("busy_ign_idle", busy, 0);
            check("busy_ign_hold", count, 10);
        end

        // Random mix of loads and steps.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_load(4'($urandom));
            end else begin
                do_step(1'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
